sdram_read: RTL

Read-back stage downstream of the ADC-to-SDRAM capture path. On a start request from the SPI module, it launches one Avalon read-master transfer of `read_length` bytes from `read_base`. It pops each 32-bit word from the master's read buffer and streams it MSB-first as bytes over a valid/ready handshake to the SPI transmitter. MSB-first order means the first-captured 16-bit sample of each packed pair leaves first.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/word_serializer.sv | 48 ++++
 rtl/sdram_read.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM read-back path.
package sdram_pkg;

   // Read-back controller states
   typedef enum logic [2:0] {
      IDLE,
      GO,
      FETCH,
      SEND,
      DRAIN,
      WAIT_DONE,
      DONE
   } state_t;

   // One SDRAM word carries four bytes on the 32-bit data path
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   // Addresses and lengths are word aligned
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/word_serializer.sv
// 32-to-8 MSB-first shift register with load, valid/ready and last-byte flag.
module word_serializer
   import sdram_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        clear,
   input  logic        ready,
   output logic [7:0]  data,
   output logic        valid,
   output logic        last
);

   logic [31:0]           shift_reg;
   logic [BYTE_IDX_W-1:0] count_reg;   // bytes still to follow the current one
   logic                  valid_reg;

   // Clear beats load beats shift; a byte advances only on a handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
         count_reg <= '0;
         valid_reg <= 1'b0;
      end else if (clear) begin
         shift_reg <= '0;
         count_reg <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         shift_reg <= load_data;
         count_reg <= BYTE_IDX_W'(BYTES_PER_WORD - 1);
         valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
         shift_reg <= {shift_reg[23:0], 8'h00};
         if (count_reg == '0) begin
            valid_reg <= 1'b0;
         end else begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign data  = shift_reg[31:24];
   assign valid = valid_reg;
   assign last  = valid_reg && (count_reg == '0);

endmodule

// File: rtl/sdram_read.sv
// Read-back controller: launches one Avalon read-master transfer and streams
// the returned words MSB-first as bytes to the SPI transmitter.
module sdram_read
   import sdram_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        read_start,
   input  logic [31:0] read_base,
   input  logic [31:0] read_length,
   input  logic        read_abort,
   output logic        busy,
   output logic        read_done,
   output logic        control_fixed_location,
   output logic [31:0] control_read_base,
   output logic [31:0] control_read_length,
   output logic        control_go,
   input  logic        control_done,
   input  logic        user_data_available,
   input  logic [31:0] user_buffer_data,
   output logic        user_read_buffer,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   state_t      state_reg, state_next;
   logic [29:0] words_left_reg, words_left_next;
   logic [31:0] base_reg, base_next;
   logic [31:0] length_reg, length_next;
   logic        ser_load, ser_clear, ser_last;
   logic        pop;

   // State, word counter and captured transfer parameters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         words_left_reg <= '0;
         base_reg       <= '0;
         length_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         words_left_reg <= words_left_next;
         base_reg       <= base_next;
         length_reg     <= length_next;
      end
   end

   // Next-state logic, pop strobe and serializer control
   always_comb begin
      state_next      = state_reg;
      words_left_next = words_left_reg;
      base_next       = base_reg;
      length_next     = length_reg;
      ser_load        = 1'b0;
      ser_clear       = 1'b0;
      pop             = 1'b0;
      case (state_reg)
         IDLE: begin
            if (read_start) begin
               base_next       = read_base & ALIGN_MASK;
               length_next     = read_length & ALIGN_MASK;
               words_left_next = read_length[31:2];
               state_next      = (read_length[31:2] == '0) ? DONE : GO;
            end
         end
         GO: begin
            state_next = read_abort ? DRAIN : FETCH;
         end
         FETCH: begin
            if (read_abort) begin
               state_next = DRAIN;
            end else if (user_data_available) begin
               pop             = 1'b1;
               ser_load        = 1'b1;
               words_left_next = words_left_reg - 30'd1;
               state_next      = SEND;
            end
         end
         SEND: begin
            if (read_abort) begin
               ser_clear  = 1'b1;
               state_next = DRAIN;
            end else if (tx_ready && ser_last) begin
               state_next = (words_left_reg == '0) ? WAIT_DONE : FETCH;
            end
         end
         DRAIN: begin
            // Every outstanding word is popped so the master never stalls
            if (words_left_reg == '0) begin
               state_next = WAIT_DONE;
            end else if (user_data_available) begin
               pop             = 1'b1;
               words_left_next = words_left_reg - 30'd1;
            end
         end
         WAIT_DONE: begin
            if (control_done) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   word_serializer u_serializer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ser_load),
      .load_data (user_buffer_data),
      .clear     (ser_clear),
      .ready     (tx_ready),
      .data      (tx_data),
      .valid     (tx_valid),
      .last      (ser_last)
   );

   assign busy                   = (state_reg != IDLE) && (state_reg != DONE);
   assign read_done              = (state_reg == DONE);
   assign control_go             = (state_reg == GO);
   assign control_fixed_location = 1'b0;
   assign control_read_base      = base_reg;
   assign control_read_length    = length_reg;
   assign user_read_buffer       = pop;

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      user_read_buffer |-> (words_left_reg != '0));

endmodule
